fifo: RTL and testbench
=======================

// Module: fifo
// PURPOSE
//  Single-clock synchronous FIFO of 2**ad_w words, each d_w bits wide.
//  Buffers data between a producer and a consumer in the same clock domain.
//  Has write/read strobes, full/empty flags and a registered read-data output.
//  Overflow and underflow are blocked internally: the FIFO is never corrupted.
// PARAMETERS
//  d_w   8  data word width in bits
//  ad_w  4  address width; depth = 2**ad_w words (16 by default)
// PORTS
//  clk       in   1     clock; all state changes on the rising edge
//  rst       in   1     reset, asynchronous, active-low
//  write     in   1     write request, sampled at the clk rising edge
//  read      in   1     read request, sampled at the clk rising edge
//  full      out  1     1 = FIFO holds 2**ad_w words
//  empty     out  1     1 = FIFO holds 0 words
//  data_in   in   d_w   write data, sampled when a write is accepted
//  data_out  out  d_w   read data, registered
// BEHAVIOUR
//  - Reset (rst=0, asynchronous, no clock needed), held while rst=0:
//    wr_ptr=0, rd_ptr=0, count=0, data_out=0, empty=1, full=0.
//    Memory contents are not cleared. Reset mid-operation discards all data.
//  - Storage: array of 2**ad_w x d_w bits.
//    Pointers are ad_w bits and wrap naturally from 2**ad_w-1 to 0.
//    count is ad_w+1 bits, range 0..2**ad_w.
//  - Flags: combinational from registered count.
//    empty = (count==0); full = (count==2**ad_w).
//    Flags are valid right after the edge that changes count.
//  - Accept rules use the flags as they stand before the edge:
//    wr_en = write & ~full; rd_en = read & ~empty.
//  - On wr_en: mem[wr_ptr] <= data_in; wr_ptr <= wr_ptr+1.
//  - On rd_en: data_out <= mem[rd_ptr]; rd_ptr <= rd_ptr+1.
//    Latency: data_out is valid one cycle after the read request (after that edge).
//  - count: +1 on wr_en only, -1 on rd_en only, unchanged when both or neither.
//  - Write while full: ignored; pointers, count, memory and flags unchanged.
//  - Read while empty: ignored; data_out keeps its last value.
//  - Simultaneous write+read, 0<count<max: both performed, count unchanged.
//  - Simultaneous write+read when empty: only the write is performed.
//    Result: count=1, data_out unchanged. No fall-through.
//  - Simultaneous write+read when full: only the read is performed.
//    Result: count=max-1.
//  - data_out holds its value whenever no read is accepted.
//  - Words are read out strictly in write order (first in, first out),
//    including across pointer wrap-around.
// TESTING
//  1 Reset: rst=0 -> empty=1, full=0, data_out=0;
//    a read while empty leaves data_out=0.
//  2 Fill: rst=1, write 16 words 1..16, one per cycle ->
//    empty=0 after the 1st write, full=1 after the 16th.
//  3 Overflow: 10 more writes (17..26) while full -> full stays 1;
//    later reads return only 1..16.
//  4 Drain: read=1 for 16+ cycles -> data_out = 1,2,...,16 on successive edges;
//    empty=1 after the 16th read; extra reads keep data_out=16.
//  5 Wrap/concurrent: write 10, read 6, then write+read together for 20 cycles ->
//    count stays 4, order preserved across pointer wrap.
//  6 Async reset mid-stream: rst=0 between edges with 5 words stored ->
//    empty=1, full=0, data_out=0 immediately; a new write/read returns the new word.

Source files
------------

// File: rtl/fifo.sv
// Single-clock synchronous FIFO with registered read data.
// Writes while full and reads while empty are dropped, so stored data is never corrupted.
module fifo #(
    parameter int unsigned d_w  = 8,
    parameter int unsigned ad_w = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           write,
    input  logic           read,
    output logic           full,
    output logic           empty,
    input  logic [d_w-1:0] data_in,
    output logic [d_w-1:0] data_out
);

    localparam int unsigned Depth = 2 ** ad_w;
    localparam logic [ad_w:0] CountMax = {1'b1, {ad_w{1'b0}}};

    logic [d_w-1:0]  mem [Depth];
    logic [ad_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [ad_w-1:0] rd_ptr_q, rd_ptr_d;
    logic [ad_w:0]   count_q, count_d;
    logic [d_w-1:0]  data_out_q, data_out_d;
    logic            wr_en, rd_en;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CountMax);
    assign data_out = data_out_q;

    // Acceptance uses the flags as they stand before the edge: a write+read
    // while empty only writes (no fall-through), and while full only reads.
    assign wr_en = write & ~full;
    assign rd_en = read & ~empty;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        data_out_d = data_out_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + ad_w'(1);
        end
        if (rd_en) begin
            rd_ptr_d   = rd_ptr_q + ad_w'(1);
            data_out_d = mem[rd_ptr_q];
        end
        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + (ad_w + 1)'(1);
            2'b01:   count_d = count_q - (ad_w + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_out_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

endmodule

// File: tb/tb_fifo.sv
// Testbench for fifo: vector table for fill/overflow/drain, hand sequences for
// wrap, simultaneous access and async reset, then random traffic against a queue model.
module tb_fifo;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;

    logic          clk;
    logic          rst;
    logic          write;
    logic          read;
    logic          full;
    logic          empty;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;

    int n_checks;
    int n_fail;

    // Reference model: a plain queue plus the last word read out.
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] model_out;

    typedef struct {
        logic          w;
        logic          r;
        logic [DW-1:0] din;
        logic          exp_empty;
        logic          exp_full;
        logic [DW-1:0] exp_dout;
    } vec_t;

    vec_t vecs[$];

    fifo #(
        .d_w  (DW),
        .ad_w (AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .write    (write),
        .read     (read),
        .full     (full),
        .empty    (empty),
        .data_in  (data_in),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string name);
        check({name, " empty"}, {7'd0, empty}, {7'd0, model_q.size() == 0});
        check({name, " full"}, {7'd0, full}, {7'd0, model_q.size() == DEPTH});
        check({name, " data_out"}, data_out, model_out);
    endtask

    // Drive one cycle; inputs change 1 time unit after the edge, outputs read there too.
    task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
        bit acc_w, acc_r;
        write   = w;
        read    = r;
        data_in = d;
        acc_w   = w && (model_q.size() < DEPTH);
        acc_r   = r && (model_q.size() > 0);
        @(posedge clk);
        #1;
        if (acc_r) model_out = model_q.pop_front();
        if (acc_w) model_q.push_back(d);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        model_out = '0;
        rst       = 1'b0;
        write     = 1'b0;
        read      = 1'b0;
        data_in   = '0;

        // Reset with no edge required.
        #2;
        check("reset empty", {7'd0, empty}, 8'd1);
        check("reset full", {7'd0, full}, 8'd0);
        check("reset data_out", data_out, 8'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Read while empty, fill 1..16, 10 overflow writes, drain 16 plus 2 extra.
        vecs.push_back('{1'b0, 1'b1, 8'd0, 1'b1, 1'b0, 8'd0});
        for (int i = 0; i < 16; i++)
            vecs.push_back('{1'b1, 1'b0, 8'(i + 1), 1'b0, (i == 15), 8'd0});
        for (int i = 0; i < 10; i++)
            vecs.push_back('{1'b1, 1'b0, 8'(i + 17), 1'b0, 1'b1, 8'd0});
        for (int i = 0; i < 18; i++)
            vecs.push_back('{1'b0, 1'b1, 8'd0, (i >= 15), 1'b0, 8'((i < 16) ? i + 1 : 16)});

        foreach (vecs[i]) begin
            step(vecs[i].w, vecs[i].r, vecs[i].din);
            check($sformatf("vec%0d empty", i), {7'd0, empty}, {7'd0, vecs[i].exp_empty});
            check($sformatf("vec%0d full", i), {7'd0, full}, {7'd0, vecs[i].exp_full});
            check($sformatf("vec%0d data_out", i), data_out, vecs[i].exp_dout);
        end

        // Wrap and concurrent access: 10 in, 6 out, then 20 cycles of both.
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'(i + 100));
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 8'd0);
            check("wrap read", data_out, 8'(i + 100));
        end
        for (int j = 0; j < 20; j++) begin
            step(1'b1, 1'b1, 8'(j + 110));
            check("concurrent data_out", data_out, 8'(j + 106));
            check("concurrent empty", {7'd0, empty}, 8'd0);
            check("concurrent full", {7'd0, full}, 8'd0);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 8'd0);
            check("wrap tail", data_out, 8'(i + 126));
        end
        check("drained empty", {7'd0, empty}, 8'd1);

        // Write+read while empty: write only, data_out unchanged.
        step(1'b1, 1'b1, 8'hC3);
        check("wr+rd empty data_out", data_out, 8'd129);
        check("wr+rd empty empty", {7'd0, empty}, 8'd0);
        step(1'b0, 1'b1, 8'd0);
        check("wr+rd empty word", data_out, 8'hC3);

        // Write+read while full: read only, count drops to max-1.
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(i + 200));
        check("refill full", {7'd0, full}, 8'd1);
        step(1'b1, 1'b1, 8'hEE);
        check("wr+rd full full", {7'd0, full}, 8'd0);
        check("wr+rd full data_out", data_out, 8'd200);
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 1'b1, 8'd0);
            check("wr+rd full order", data_out, 8'(i + 201));
        end
        check("wr+rd full drained", {7'd0, empty}, 8'd1);

        // Asynchronous reset between edges with 5 words stored.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(i + 50));
        step(1'b0, 1'b1, 8'd0);
        write = 1'b0;
        read  = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("async rst empty", {7'd0, empty}, 8'd1);
        check("async rst full", {7'd0, full}, 8'd0);
        check("async rst data_out", data_out, 8'd0);
        model_q.delete();
        model_out = '0;
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 1'b0, 8'h5A);
        step(1'b0, 1'b1, 8'd0);
        check("post rst word", data_out, 8'h5A);
        check("post rst empty", {7'd0, empty}, 8'd1);

        // Random traffic: write-heavy phase then read-heavy phase.
        for (int i = 0; i < 400; i++) begin
            bit w, r;
            if (i < 200) begin
                w = ($urandom_range(0, 3) != 0);
                r = ($urandom_range(0, 3) == 0);
            end else begin
                w = ($urandom_range(0, 3) == 0);
                r = ($urandom_range(0, 3) != 0);
            end
            step(w, r, 8'($urandom));
            check_model($sformatf("rand%0d", i));
        end

        write = 1'b0;
        read  = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
